// File: rtl/ftl_page_arb.sv
// Two-requester arbiter in front of the physical page-operation port.
// Serialises page commands from r0 (foreground) and r1 (maintenance), routes responses back, supervises completion.
module ftl_page_arb #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        r0_op_page_do,
    input  logic [2:0]  r0_op_page_cmd,
    input  logic [15:0] r0_op_page_num,
    input  logic [15:0] r0_op_page_bram,
    input  logic [41:0] r0_op_page_spare_wr,
    output logic        r0_op_page_ack,
    output logic        r0_op_page_done,
    output logic        r0_op_page_status,
    output logic [41:0] r0_op_page_spare_rd,
    input  logic        r1_op_page_do,
    input  logic [2:0]  r1_op_page_cmd,
    input  logic [15:0] r1_op_page_num,
    input  logic [15:0] r1_op_page_bram,
    input  logic [41:0] r1_op_page_spare_wr,
    output logic        r1_op_page_ack,
    output logic        r1_op_page_done,
    output logic        r1_op_page_status,
    output logic [41:0] r1_op_page_spare_rd,
    output logic        op_page_do,
    output logic [2:0]  op_page_cmd,
    output logic [15:0] op_page_num,
    output logic [15:0] op_page_bram,
    output logic [41:0] op_page_spare_wr,
    input  logic        op_page_ack,
    input  logic        op_page_done,
    input  logic        op_page_status,
    input  logic [41:0] op_page_spare_rd,
    output logic        dbg_owner,
    output logic        err_timeout
);
    // Handshake: a requester holds do high with stable fields until it sees a one-cycle ack;
    // done (with status/spare_rd) follows as a one-cycle pulse, possibly in the ack cycle.

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [23:0] WD_LAST    = 24'(TIMEOUT_CYCLES - 1);
    localparam bit          WD_EN      = (TIMEOUT_CYCLES != 0);

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic [23:0] wd_cnt, wd_nxt;
    logic        err_nxt;

    logic        own_do;
    logic [2:0]  own_cmd;
    logic [15:0] own_num;
    logic [15:0] own_bram;
    logic [41:0] own_spare_wr;

    logic        fwd_ack;
    logic        fwd_done;
    logic        fwd_status;
    logic [41:0] fwd_spare_rd;

    assign own_do       = owner ? r1_op_page_do       : r0_op_page_do;
    assign own_cmd      = owner ? r1_op_page_cmd      : r0_op_page_cmd;
    assign own_num      = owner ? r1_op_page_num      : r0_op_page_num;
    assign own_bram     = owner ? r1_op_page_bram     : r0_op_page_bram;
    assign own_spare_wr = owner ? r1_op_page_spare_wr : r0_op_page_spare_wr;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            starve_cnt  <= 4'd0;
            wd_cnt      <= 24'd0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            starve_cnt  <= starve_nxt;
            wd_cnt      <= wd_nxt;
            err_timeout <= err_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        starve_nxt       = starve_cnt;
        wd_nxt           = wd_cnt;
        err_nxt          = err_timeout;
        op_page_do       = 1'b0;
        op_page_cmd      = 3'd0;
        op_page_num      = 16'd0;
        op_page_bram     = 16'd0;
        op_page_spare_wr = 42'd0;
        fwd_ack          = 1'b0;
        fwd_done         = 1'b0;
        fwd_status       = 1'b0;
        fwd_spare_rd     = 42'd0;

        case (state)
            IDLE: begin
                if (r0_op_page_do || r1_op_page_do) begin
                    // r0 has priority until it has won STARVE_LIMIT times in a row over a waiting r1
                    owner_nxt = r1_op_page_do && (!r0_op_page_do || starve_cnt == STARVE_MAX);
                    if (owner_nxt)
                        starve_nxt = 4'd0;
                    else if (r1_op_page_do && starve_cnt != STARVE_MAX)
                        starve_nxt = starve_cnt + 4'd1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                op_page_do       = own_do;
                op_page_cmd      = own_cmd;
                op_page_num      = own_num;
                op_page_bram     = own_bram;
                op_page_spare_wr = own_spare_wr;
                fwd_ack          = op_page_ack;
                if (op_page_ack) begin
                    if (op_page_done) begin
                        fwd_done     = 1'b1;
                        fwd_status   = op_page_status;
                        fwd_spare_rd = op_page_spare_rd;
                        state_nxt    = IDLE;
                    end else begin
                        wd_nxt    = 24'd0;
                        state_nxt = WAIT_DONE;
                    end
                end else if (!own_do) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                wd_nxt = wd_cnt + 24'd1;
                if (op_page_done) begin
                    fwd_done     = 1'b1;
                    fwd_status   = op_page_status;
                    fwd_spare_rd = op_page_spare_rd;
                    state_nxt    = IDLE;
                end else if (WD_EN && wd_cnt == WD_LAST) begin
                    // synthetic failure completion so the owner is never left hanging
                    fwd_done   = 1'b1;
                    fwd_status = 1'b1;
                    err_nxt    = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign r0_op_page_ack      = fwd_ack & ~owner;
    assign r0_op_page_done     = fwd_done & ~owner;
    assign r0_op_page_status   = fwd_status & ~owner;
    assign r0_op_page_spare_rd = owner ? 42'd0 : fwd_spare_rd;
    assign r1_op_page_ack      = fwd_ack & owner;
    assign r1_op_page_done     = fwd_done & owner;
    assign r1_op_page_status   = fwd_status & owner;
    assign r1_op_page_spare_rd = owner ? fwd_spare_rd : 42'd0;
    assign dbg_owner           = owner;

endmodule

// File: tb/tb_ftl_page_arb.sv
// Bench for ftl_page_arb: table-driven transactions, hand-written corner sequences,
// then randomized traffic checked against a transaction-level grant/route model.
module tb_ftl_page_arb;
    localparam int STARVE_LIMIT   = 4;
    localparam int TIMEOUT_CYCLES = 100;

    logic clk_50 = 1'b0;
    logic reset_n;

    logic        req_do[2];
    logic [2:0]  req_cmd[2];
    logic [15:0] req_num[2];
    logic [15:0] req_bram[2];
    logic [41:0] req_spare[2];

    logic        dn_ack, dn_done, dn_status;
    logic [41:0] dn_spare;

    logic        r0_op_page_ack, r0_op_page_done, r0_op_page_status;
    logic [41:0] r0_op_page_spare_rd;
    logic        r1_op_page_ack, r1_op_page_done, r1_op_page_status;
    logic [41:0] r1_op_page_spare_rd;
    logic        op_page_do;
    logic [2:0]  op_page_cmd;
    logic [15:0] op_page_num, op_page_bram;
    logic [41:0] op_page_spare_wr;
    logic        dbg_owner, err_timeout;

    logic [89:0] resp_vec;
    logic [77:0] req_out;
    logic [77:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    assign resp_vec = {r0_op_page_ack, r0_op_page_done, r0_op_page_status, r0_op_page_spare_rd,
                       r1_op_page_ack, r1_op_page_done, r1_op_page_status, r1_op_page_spare_rd};
    assign req_out  = {dbg_owner, op_page_cmd, op_page_num, op_page_bram, op_page_spare_wr};

    ftl_page_arb #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk_50(clk_50), .reset_n(reset_n),
        .r0_op_page_do(req_do[0]), .r0_op_page_cmd(req_cmd[0]), .r0_op_page_num(req_num[0]),
        .r0_op_page_bram(req_bram[0]), .r0_op_page_spare_wr(req_spare[0]),
        .r0_op_page_ack(r0_op_page_ack), .r0_op_page_done(r0_op_page_done),
        .r0_op_page_status(r0_op_page_status), .r0_op_page_spare_rd(r0_op_page_spare_rd),
        .r1_op_page_do(req_do[1]), .r1_op_page_cmd(req_cmd[1]), .r1_op_page_num(req_num[1]),
        .r1_op_page_bram(req_bram[1]), .r1_op_page_spare_wr(req_spare[1]),
        .r1_op_page_ack(r1_op_page_ack), .r1_op_page_done(r1_op_page_done),
        .r1_op_page_status(r1_op_page_status), .r1_op_page_spare_rd(r1_op_page_spare_rd),
        .op_page_do(op_page_do), .op_page_cmd(op_page_cmd), .op_page_num(op_page_num),
        .op_page_bram(op_page_bram), .op_page_spare_wr(op_page_spare_wr),
        .op_page_ack(dn_ack), .op_page_done(dn_done), .op_page_status(dn_status),
        .op_page_spare_rd(dn_spare),
        .dbg_owner(dbg_owner), .err_timeout(err_timeout)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_50 = ~clk_50;

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no finish, required finish");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_50);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_50);
    endtask

    function automatic logic [89:0] exp_resp(input logic w, input logic a, input logic d,
                                              input logic s, input logic [41:0] sp);
        logic [44:0] h;
        h = {a, d, d & s, d ? sp : 42'd0};
        return w ? {45'd0, h} : {h, 45'd0};
    endfunction

    task automatic clear_dn();
        dn_ack = 1'b0; dn_done = 1'b0; dn_status = 1'b0; dn_spare = 42'd0;
    endtask

    task automatic set_fields(input int r, input logic [2:0] c, input logic [15:0] n,
                              input logic [15:0] b, input logic [41:0] s);
        req_cmd[r] = c; req_num[r] = n; req_bram[r] = b; req_spare[r] = s;
    endtask

    // ---------------- table-driven transactions ----------------
    typedef struct {
        logic [1:0]  req;
        logic [2:0]  cmd;
        logic [15:0] num;
        logic [15:0] bram;
        logic [41:0] spare_wr;
        int          ack_dly;
        int          done_dly;
        logic        status;
        logic [41:0] spare_rd;
        logic        exp_owner;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [1:0] rq, input logic [2:0] c, input logic [15:0] n,
                                input logic [15:0] b, input logic [41:0] sw, input int ad,
                                input int dd, input logic st, input logic [41:0] sr, input logic ow);
        vec_t v;
        v.req = rq; v.cmd = c; v.num = n; v.bram = b; v.spare_wr = sw;
        v.ack_dly = ad; v.done_dly = dd; v.status = st; v.spare_rd = sr; v.exp_owner = ow;
        vecs.push_back(v);
    endfunction

    // r0 drives the row fields, r1 their bitwise inverse; the loser keeps do high
    task automatic run_vec(input vec_t v);
        logic [76:0] f0;
        logic [77:0] ef;
        logic        w;
        w  = v.exp_owner;
        f0 = {v.cmd, v.num, v.bram, v.spare_wr};
        ef = {w, w ? ~f0 : f0};
        cyc();
        clear_dn();
        req_do[0] = v.req[0];
        req_do[1] = v.req[1];
        set_fields(0, v.cmd, v.num, v.bram, v.spare_wr);
        set_fields(1, ~v.cmd, ~v.num, ~v.bram, ~v.spare_wr);
        smp();
        chk("idle_gap_do", 128'(op_page_do), 128'(0));
        for (int k = 0; k <= v.ack_dly; k++) begin
            cyc();
            if (k == v.ack_dly) begin
                dn_ack = 1'b1;
                if (v.done_dly == 0) begin
                    dn_done = 1'b1; dn_status = v.status; dn_spare = v.spare_rd;
                end
            end
            smp();
            chk("issue_do", 128'(op_page_do), 128'(1));
            chk("issue_fields", 128'(req_out), 128'(ef));
            chk("issue_resp", 128'(resp_vec),
                128'(exp_resp(w, k == v.ack_dly, (k == v.ack_dly) && (v.done_dly == 0),
                              v.status, v.spare_rd)));
        end
        for (int k = 1; k <= v.done_dly; k++) begin
            cyc();
            dn_ack = 1'b0;
            if (k == 1) req_do[w] = 1'b0;
            if (k == v.done_dly) begin
                dn_done = 1'b1; dn_status = v.status; dn_spare = v.spare_rd;
            end
            smp();
            chk("wait_do", 128'(op_page_do), 128'(0));
            chk("wait_resp", 128'(resp_vec),
                128'(exp_resp(w, 1'b0, k == v.done_dly, v.status, v.spare_rd)));
        end
    endtask

    // ---------------- randomized traffic with reference model ----------------
    task automatic run_random(input int n);
        logic [1:0]  saw_ack, saw_done, pend;
        int          gap[2];
        int          dn_phase, dn_cnt, streak;
        bit          model_free, no_new;
        logic        prev_do, cur, w;
        logic [77:0] g;
        saw_ack = 2'b00; saw_done = 2'b00; pend = 2'b00;
        gap[0] = 0; gap[1] = 0;
        dn_phase = 0; dn_cnt = 0; streak = 0;
        model_free = 1'b1; prev_do = 1'b0; cur = 1'b0;
        for (int i = 0; i < n; i++) begin
            cyc();
            no_new = (i >= n - 60);
            clear_dn();
            for (int r = 0; r < 2; r++) begin
                if (saw_ack[r]) begin
                    req_do[r] = 1'b0;
                    pend[r]   = 1'b1;
                end
                if (saw_done[r]) begin
                    pend[r] = 1'b0;
                    gap[r]  = $urandom_range(0, 3);
                end else if (!req_do[r] && !pend[r]) begin
                    if (gap[r] > 0) gap[r]--;
                    else if (!no_new) begin
                        req_do[r] = 1'b1;
                        set_fields(r, 3'($urandom), 16'($urandom), 16'($urandom),
                                   42'({$urandom, $urandom}));
                    end
                end
            end
            if (dn_phase == 1) begin
                if (dn_cnt == 0) begin
                    dn_ack = 1'b1;
                    dn_cnt = $urandom_range(0, 5);
                    if (dn_cnt == 0) begin
                        dn_done = 1'b1; dn_status = 1'($urandom_range(0, 1));
                        dn_spare = 42'({$urandom, $urandom});
                        dn_phase = 0;
                    end else dn_phase = 2;
                end else dn_cnt--;
            end else if (dn_phase == 2) begin
                dn_cnt--;
                if (dn_cnt == 0) begin
                    dn_done = 1'b1; dn_status = 1'($urandom_range(0, 1));
                    dn_spare = 42'({$urandom, $urandom});
                    dn_phase = 0;
                end
            end
            smp();
            // arbitration decision for a free arbiter seeing requests this cycle
            if (model_free && (req_do[0] || req_do[1])) begin
                w = req_do[1] && (!req_do[0] || streak == STARVE_LIMIT);
                if (w) streak = 0;
                else if (req_do[1] && streak < STARVE_LIMIT) streak++;
                exp_q.push_back({w, req_cmd[w], req_num[w], req_bram[w], req_spare[w]});
                model_free = 1'b0;
            end
            if (dn_done) model_free = 1'b1;
            if (dn_phase == 0 && op_page_do && !dn_ack) begin
                dn_phase = 1;
                dn_cnt   = $urandom_range(0, 2);
            end
            if (op_page_do && !prev_do) begin
                chk("rnd_grant_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    g   = exp_q.pop_front();
                    cur = g[77];
                    chk("rnd_grant_fields", 128'(req_out), 128'(g));
                end
            end
            prev_do = op_page_do;
            chk("rnd_resp", 128'(resp_vec), 128'(exp_resp(cur, dn_ack, dn_done, dn_status, dn_spare)));
            saw_ack  = {r1_op_page_ack, r0_op_page_ack};
            saw_done = {r1_op_page_done, r0_op_page_done};
        end
        chk("rnd_drain", 128'(exp_q.size()), 128'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int early;
        reset_n = 1'b0;
        req_do[0] = 1'b0; req_do[1] = 1'b0;
        set_fields(0, 3'd0, 16'd0, 16'd0, 42'd0);
        set_fields(1, 3'd0, 16'd0, 16'd0, 42'd0);
        clear_dn();
        repeat (3) cyc();
        smp();
        chk("reset_req_out", 128'({op_page_do, req_out}), 128'(0));
        chk("reset_resp", 128'(resp_vec), 128'(0));
        chk("reset_err", 128'(err_timeout), 128'(0));
        cyc();
        reset_n = 1'b1;

        add(2'b01, 3'd2, 16'h0123, 16'h0400, 42'h3FFFF00001, 3, 10, 1'b0, 42'h2A, 1'b0);
        add(2'b10, 3'd5, 16'hBEEF, 16'h1000, 42'h15555555555, 1, 2, 1'b1, 42'h3FFFFFFFFFF, 1'b1);
        for (int i = 0; i < 10; i++)
            add(2'b11, 3'(i), 16'(i * 16'h1111), 16'(16'h2000 + i), 42'(i * 7 + 1),
                i % 3, 1 + (i % 4), 1'(i % 2), 42'(i * 3 + 5), 1'((i == 4) || (i == 9)));
        add(2'b11, 3'd7, 16'hFFFF, 16'h0000, 42'h0, 1, 0, 1'b0, 42'h123, 1'b0);
        add(2'b10, 3'd1, 16'h8000, 16'h7FFF, 42'h2AA, 0, 3, 1'b1, 42'h0, 1'b1);
        add(2'b01, 3'd3, 16'h00FF, 16'hFF00, 42'h3FF00000000, 2, 1, 1'b1, 42'h200000001, 1'b0);
        foreach (vecs[i]) run_vec(vecs[i]);

        // watchdog: r1 acked, never completed
        cyc();
        clear_dn();
        req_do[0] = 1'b0; req_do[1] = 1'b1;
        set_fields(1, 3'd6, 16'h0D0D, 16'h0E0E, 42'h0F0F);
        smp();
        cyc();
        dn_ack = 1'b1;
        smp();
        chk("wd_ack", 128'(resp_vec), 128'(exp_resp(1'b1, 1'b1, 1'b0, 1'b0, 42'd0)));
        early = 0;
        for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
            cyc();
            dn_ack = 1'b0;
            if (k == 1) req_do[1] = 1'b0;
            smp();
            if (k < TIMEOUT_CYCLES) begin
                if (r0_op_page_done || r1_op_page_done || err_timeout) early++;
            end else begin
                chk("wd_fire", 128'(resp_vec), 128'(exp_resp(1'b1, 1'b0, 1'b1, 1'b1, 42'd0)));
            end
        end
        chk("wd_early", 128'(early), 128'(0));
        for (int k = 1; k <= 6; k++) begin
            cyc();
            clear_dn();
            if (k == 5) begin dn_done = 1'b1; dn_spare = 42'h55; end
            smp();
            if (k == 5) chk("wd_late_done_dropped", 128'(resp_vec), 128'(0));
            if (k == 1 || k == 6) chk("wd_err_sticky", 128'(err_timeout), 128'(1));
        end

        // abandoned r0 request with r1 queued
        cyc();
        clear_dn();
        req_do[0] = 1'b1; req_do[1] = 1'b1;
        set_fields(0, 3'd4, 16'hAAAA, 16'h0101, 42'h11);
        set_fields(1, 3'd5, 16'h5555, 16'h0202, 42'h22);
        smp();
        chk("ab_idle", 128'(op_page_do), 128'(0));
        for (int k = 0; k < 2; k++) begin
            cyc();
            smp();
            chk("ab_issue", 128'({op_page_do, dbg_owner, op_page_num}), 128'({1'b1, 1'b0, 16'hAAAA}));
        end
        cyc();
        req_do[0] = 1'b0;
        smp();
        chk("ab_drop_do", 128'(op_page_do), 128'(0));
        chk("ab_drop_resp", 128'(resp_vec), 128'(0));
        cyc();
        smp();
        chk("ab_idle2", 128'(op_page_do), 128'(0));
        cyc();
        smp();
        chk("ab_r1_grant", 128'({op_page_do, dbg_owner, op_page_num}), 128'({1'b1, 1'b1, 16'h5555}));
        cyc();
        dn_ack = 1'b1; dn_done = 1'b1; dn_spare = 42'h1;
        smp();
        chk("ab_r1_done", 128'(resp_vec), 128'(exp_resp(1'b1, 1'b1, 1'b1, 1'b0, 42'h1)));
        cyc();
        clear_dn();
        req_do[1] = 1'b0;
        smp();

        // asynchronous reset while r1 sits in WAIT_DONE
        cyc();
        req_do[1] = 1'b1;
        smp();
        cyc();
        dn_ack = 1'b1;
        smp();
        chk("rst_pre_ack", 128'(resp_vec), 128'(exp_resp(1'b1, 1'b1, 1'b0, 1'b0, 42'd0)));
        cyc();
        dn_ack = 1'b0;
        req_do[1] = 1'b0;
        smp();
        chk("rst_pre_flags", 128'({err_timeout, dbg_owner}), 128'(2'b11));
        #3 reset_n = 1'b0;
        #1;
        chk("rst_async_req", 128'({op_page_do, req_out}), 128'(0));
        chk("rst_async_resp", 128'(resp_vec), 128'(0));
        chk("rst_async_flags", 128'({err_timeout, dbg_owner}), 128'(0));
        smp();
        #2 reset_n = 1'b1;
        cyc();
        dn_done = 1'b1; dn_status = 1'b1; dn_spare = 42'h3FF;
        smp();
        chk("rst_late_done", 128'({op_page_do, resp_vec}), 128'(0));
        cyc();
        clear_dn();
        dn_ack = 1'b1;
        smp();
        chk("idle_stray_ack", 128'(resp_vec), 128'(0));
        cyc();
        clear_dn();

        run_random(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ftl_page_arb.md
# ftl_page_arb

Two-requester arbiter for the FTL page-operation port of the physical layer. The foreground translator (`ftl_logical`) is requester 0. A background maintenance engine (scrub/wear-level) is requester 1. The block sits between both requesters and `ftl_physical`, serialises their page commands, routes each handshake back to the requester that issued it, and supervises completion with a watchdog.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: number of consecutive r0 grants allowed while r1 is waiting; the next decision then goes to r1. Range 1–15.
- `TIMEOUT_CYCLES`, 2_000_000: cycles allowed in WAIT_DONE before a synthetic failure completion; 0 disables the watchdog. Counter width is 24 bits.

Ports (rN = r0, r1; each group is identical):
- `clk_50`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rN_op_page_do`  in  1  request; held high with fields stable until rN_op_page_ack.
- `rN_op_page_cmd`  in  3  page command.
- `rN_op_page_num`  in  16  physical page number.
- `rN_op_page_bram`  in  16  page-buffer base address.
- `rN_op_page_spare_wr`  in  42  spare-area write data.
- `rN_op_page_ack`  out  1  one-cycle acceptance pulse.
- `rN_op_page_done`  out  1  one-cycle completion pulse.
- `rN_op_page_status`  out  1  completion status, valid with done; 1 = fail.
- `rN_op_page_spare_rd`  out  42  spare-area read data, valid with done.
- `op_page_do`, `op_page_cmd[2:0]`, `op_page_num[15:0]`, `op_page_bram[15:0]`, `op_page_spare_wr[41:0]`  out  muxed request to `ftl_physical`.
- `op_page_ack`, `op_page_done`, `op_page_status`, `op_page_spare_rd[41:0]`  in  responses from `ftl_physical`.
- `dbg_owner`  out  1  current/last grant owner.
- `err_timeout`  out  1  sticky watchdog flag; cleared only by reset.

## Operation
States: IDLE, ISSUE, WAIT_DONE.

IDLE:
- If any `rN_op_page_do` is high, latch the winner into `owner` and go to ISSUE.
- Winner selection: if only one requester is high, it wins. If both are high, r0 wins unless `starve_cnt == STARVE_LIMIT`, in which case r1 wins.
- `starve_cnt` (4 bits) increments on every r0 grant made while r1_do is high. It clears on any r1 grant and saturates at STARVE_LIMIT.

ISSUE:
- `op_page_do` is the owner's do, passed through combinationally.
- All downstream request fields come combinationally from the owner's inputs.
- `op_page_ack` is routed combinationally to `owner_ack`.
- On ack without done: go to WAIT_DONE.
- On ack and done in the same cycle: forward both pulses, then go to IDLE.
- If the owner drops do with no ack: go to IDLE (abandoned request); nothing is forwarded.

WAIT_DONE:
- `op_page_do` = 0.
- `op_page_done`, `op_page_status` and `op_page_spare_rd` are routed combinationally to the owner. On done, go to IDLE.
- Watchdog counter clears on entry and increments each cycle in this state.
- When the counter equals TIMEOUT_CYCLES-1 with no done (TIMEOUT_CYCLES ≠ 0):
  - pulse `owner_done` with status = 1 and spare_rd = 0;
  - set `err_timeout`;
  - go to IDLE.
- Done and timeout in the same cycle: the real done wins and err_timeout is not set.

General rules:
- An `op_page_done` or `op_page_ack` arriving in IDLE is discarded and not forwarded to either requester.
- The non-owner's ack/done/status outputs are 0 at all times. Its spare_rd output is 0.
- While in IDLE, all downstream request outputs are 0.

## Timing
- Reset: state IDLE, owner = 0, starve_cnt = 0, watchdog = 0, `err_timeout` = 0, `dbg_owner` = 0. All ack/done/do/status outputs are 0 and all data outputs are 0.
- Grant latency: rN_do is sampled high in IDLE at edge N; `op_page_do` is high from cycle N+1.
- Ack/done/status/spare_rd are combinational pass-throughs with zero added latency.
- Back-to-back requests: after done at edge M the arbiter is in IDLE in cycle M+1, and the next `op_page_do` appears at M+2. This gives one dead cycle minimum between commands.
- The watchdog fires exactly TIMEOUT_CYCLES cycles after entering WAIT_DONE.
- Asserting reset mid-transaction aborts immediately: no done is issued, and a late physical done after release is discarded in IDLE.

## Test plan
- **Single request:** r0 requests cmd=3'd2, num=16'h0123, bram=16'h0400, spare_wr=42'h3_FFFF_0000_1 → same fields on the downstream port at cycle +1. A physical ack 3 cycles later and a done with status=0, spare_rd=42'h2A after 10 more cycles → r0 sees one ack pulse and one done with spare_rd=42'h2A. r1 outputs stay 0.
- **Starvation guard:** STARVE_LIMIT=4, r0 and r1 requesting continuously → grant order r0,r0,r0,r0,r1,r0,r0,r0,r0,r1; starve_cnt returns to 0 after each r1 grant.
- **Watchdog:** TIMEOUT_CYCLES=100, r1 acked but never done → r1_done pulses with status=1 and spare_rd=0 exactly 100 cycles after the ack edge. err_timeout goes high and stays high. A done injected 5 cycles later is not forwarded to either requester.
- **Same-cycle ack and done:** ack and done arrive together in ISSUE → owner receives both pulses in that cycle and the arbiter returns to IDLE; a queued r1 request sees `op_page_do` 2 cycles later.
- **Abandoned request:** r0 drops do after 2 cycles in ISSUE with no ack → IDLE next cycle, no pulses, and r1 is then granted.
- **Reset mid-operation:** reset_n is asserted during WAIT_DONE, asynchronously and not clock-aligned → all outputs are 0 before the next clock edge and err_timeout is cleared. After release, physical done pulses are ignored.
